// File: rtl/pio_stream_out_pkg.sv
// pio_stream_out shared constants: Avalon register addresses and
// STATUS/CTRL bit positions used by the block and its software driver.
package pio_stream_out_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int STAT_FULL  = 16;
    localparam int STAT_EMPTY = 17;
    localparam int STAT_OVF   = 18;

    localparam int CTRL_FLUSH    = 0;
    localparam int CTRL_CLR_OVF  = 1;
    localparam int CTRL_IRQ_MASK = 2;

endpackage

// File: rtl/pio_fifo_sync.sv
// pio_fifo_sync: synchronous FIFO with fill counter and flush.
// Full is judged from the pre-cycle count; flush beats a same-cycle pop.
module pio_fifo_sync #(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  next_count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign count   = cnt_q;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_comb begin
        next_count = cnt_q;
        if (flush)
            next_count = '0;
        else if (do_push && !do_pop)
            next_count = cnt_q + CNT_W'(1);
        else if (do_pop && !do_push)
            next_count = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= next_count;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pio_stream_out.sv
// pio_stream_out: Avalon-MM write PIO feeding a valid/ready stream.
// Define PIO_STREAM_OUT_IRQ_EN to get the "FIFO drained" irq output.
module pio_stream_out
    import pio_stream_out_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef PIO_STREAM_OUT_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic             wr_en;
    logic             push;
    logic             ctrl_wr;
    logic             flush;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             irq_mask;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic [31:0]      rdata_d;

    assign wr_en   = chipselect & ~write_n;
    assign push    = wr_en & (address == ADDR_DATA);
    assign ctrl_wr = wr_en & (address == ADDR_CTRL);
    assign flush   = ctrl_wr & writedata[CTRL_FLUSH];
    assign out_valid = ~empty;

    pio_fifo_sync #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (writedata[DATA_W-1:0]),
        .pop        (out_valid & out_ready),
        .flush      (flush),
        .rd_data    (out_data),
        .count      (count),
        .next_count (next_count),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (push && full)
            overflow <= 1'b1;
        else if (ctrl_wr && writedata[CTRL_CLR_OVF])
            overflow <= 1'b0;
    end

`ifdef PIO_STREAM_OUT_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ctrl_wr)
                irq_mask <= writedata[CTRL_IRQ_MASK];
            irq <= irq_mask & (next_count == '0);
        end
    end
`else
    assign irq_mask = 1'b0;
`endif

    always_comb begin
        rdata_d = '0;
        unique case (address)
            ADDR_STATUS: begin
                rdata_d[CNT_W-1:0]  = count;
                rdata_d[STAT_FULL]  = full;
                rdata_d[STAT_EMPTY] = empty;
                rdata_d[STAT_OVF]   = overflow;
            end
            ADDR_CTRL: rdata_d[CTRL_IRQ_MASK] = irq_mask;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rdata_d;
    end

endmodule

// File: tb/tb_pio_stream_out.sv
// Directed self-checking bench for pio_stream_out (DEPTH=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_pio_stream_out;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef PIO_STREAM_OUT_IRQ_EN
    logic        irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pio_stream_out #(.DEPTH(8), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef PIO_STREAM_OUT_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic avl_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic avl_rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    logic [31:0] rd;
    int sent, got, mcount;
    logic do_w, mpop;

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", out_data, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        avl_rd(2'd1, rd);
        chk("status_reset", rd, 32'h0002_0000);
        chk("valid_idle", 32'(out_valid), 32'h0);

        avl_wr(2'd0, 32'hDEAD_BEEF);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", out_data, 32'hDEAD_BEEF);
        avl_rd(2'd1, rd);
        chk("single_status", rd, 32'h0000_0001);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("single_popped", 32'(out_valid), 32'h0);

        for (int i = 1; i <= 9; i++)
            avl_wr(2'd0, 32'(i));
        avl_rd(2'd1, rd);
        chk("ovf_status", rd, 32'h0005_0008);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", out_data, 32'(i));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'h0);
        avl_wr(2'd2, 32'h2);
        avl_rd(2'd1, rd);
        chk("clr_ovf", rd, 32'h0002_0000);

        sent   = 0;
        got    = 0;
        mcount = 0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            out_ready  = (cyc % 2 == 1);
            do_w       = (sent < 20) && (mcount < 8);
            address    = 2'd0;
            writedata  = 32'h1000 + 32'(sent);
            chipselect = do_w;
            write_n    = !do_w;
            mpop       = (mcount > 0) && out_ready;
            if (mpop) begin
                chk("stream_data", out_data, 32'h1000 + 32'(got));
                got++;
            end
            if (do_w) sent++;
            mcount = mcount + int'(do_w) - int'(mpop);
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        out_ready  = 1'b0;
        chk("stream_count", 32'(got), 32'd20);
        avl_rd(2'd1, rd);
        chk("stream_status", rd, 32'h0002_0000);

        for (int i = 0; i < 8; i++)
            avl_wr(2'd0, 32'h100 + 32'(i));
        out_ready = 1'b1;
        avl_wr(2'd0, 32'h999);
        out_ready = 1'b0;
        chk("full_pop_head", out_data, 32'h101);
        avl_rd(2'd1, rd);
        chk("full_pop_status", rd, 32'h0004_0007);

        avl_wr(2'd2, 32'h1);
        avl_rd(2'd1, rd);
        chk("flush1_status", rd, 32'h0006_0000);
        for (int i = 0; i < 5; i++)
            avl_wr(2'd0, 32'h200 + 32'(i));
        avl_rd(2'd1, rd);
        chk("fill5_status", rd, 32'h0004_0005);
        out_ready = 1'b1;
        avl_wr(2'd2, 32'h1);
        out_ready = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'h0);
        avl_rd(2'd1, rd);
        chk("flush2_status", rd, 32'h0006_0000);
        avl_wr(2'd0, 32'hCAFE_0001);
        chk("post_flush_data", out_data, 32'hCAFE_0001);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        avl_wr(2'd2, 32'h2);
        avl_rd(2'd1, rd);
        chk("clr_ovf2", rd, 32'h0002_0000);

        avl_rd(2'd0, rd);
        chk("read_addr0", rd, 32'h0);
        avl_rd(2'd3, rd);
        chk("read_addr3", rd, 32'h0);
        avl_wr(2'd3, 32'hFFFF_FFFF);
        avl_wr(2'd1, 32'hFFFF_FFFF);
        avl_rd(2'd1, rd);
        chk("ignored_writes", rd, 32'h0002_0000);

        for (int i = 0; i < 3; i++)
            avl_wr(2'd0, 32'h300 + 32'(i));
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", out_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        avl_rd(2'd1, rd);
        chk("midrst_status", rd, 32'h0002_0000);

        avl_wr(2'd2, 32'h4);
        avl_rd(2'd2, rd);
`ifdef PIO_STREAM_OUT_IRQ_EN
        chk("ctrl_readback", rd, 32'h4);
        avl_wr(2'd0, 32'hA);
        chk("irq_fill1", 32'(irq), 32'h0);
        avl_wr(2'd0, 32'hB);
        out_ready = 1'b1;
        @(negedge clk);
        chk("irq_pop1", 32'(irq), 32'h0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("irq_drained", 32'(irq), 32'h1);
        chk("irq_empty", 32'(out_valid), 32'h0);
        avl_wr(2'd0, 32'hC);
        chk("irq_cleared", 32'(irq), 32'h0);
`else
        chk("ctrl_readback", rd, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
